// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the core's M stage and a slow
// data memory. Stores are queued in a small circular FIFO and drained over a
// req/ack bus; loads forward from the youngest matching queued store or, on a
// miss, issue a read and stall the core until the data returns.

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [AW-1:0] ALUResultM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          StallMem,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic          MemAck,
  input  logic [DW-1:0] MemRData,
  output logic          Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  logic [AW-1:0] entryAddr_q [DEPTH];
  logic [DW-1:0] entryData_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;

  logic          memReq_q;
  logic          memWe_q;
  logic [AW-1:0] memAddr_q;
  logic [DW-1:0] memWData_q;
  logic [DW-1:0] readData_q;
  logic          loaded_q;

  logic          full;
  logic          push;
  logic          pop;
  logic          fwdHit;
  logic [DW-1:0] fwdData;
  logic          loadMiss;
  logic [PW-1:0] slotIdx [DEPTH];

  // slotIdx[k] is the FIFO slot k positions younger than head, so slot 0 is
  // the oldest entry and slot count-1 the youngest.
  for (genvar g = 0; g < DEPTH; g++) begin : gen_slot
    assign slotIdx[g] = head_q + PW'(g);
  end

  assign full     = (count_q == CW'(DEPTH));
  assign push     = MemWriteM && !full;
  assign pop      = (state_q == WR) && MemAck;
  assign loadMiss = MemReadM && !MemWriteM && !loaded_q && !fwdHit;

  assign MemReq   = memReq_q;
  assign MemWe    = memWe_q;
  assign MemAddr  = memAddr_q;
  assign MemWData = memWData_q;
  assign Empty    = (count_q == '0) && (state_q != WR);

  // Search valid entries oldest to youngest so the youngest word match wins.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) &&
          (entryAddr_q[slotIdx[i]][AW-1:2] == ALUResultM[AW-1:2])) begin
        fwdHit  = 1'b1;
        fwdData = entryData_q[slotIdx[i]];
      end
    end
  end

  // Stall and load-data selection; a store wins over a simultaneous load.
  always_comb begin
    StallMem  = 1'b0;
    ReadDataM = readData_q;
    if (MemWriteM) begin
      StallMem = full;
    end else if (MemReadM && !loaded_q) begin
      if (fwdHit) begin
        ReadDataM = fwdData;
      end else begin
        StallMem = 1'b1;
      end
    end
    if (!reset) begin
      StallMem = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping; a freed slot is only visible next cycle.
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Entry storage needs no reset since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr_q[tail_q] <= ALUResultM;
      entryData_q[tail_q] <= WriteDataM;
    end
  end

  // Memory-side FSM with registered bus outputs and load completion flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWData_q <= '0;
      readData_q <= '0;
      loaded_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (loaded_q) begin
        loaded_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (loadMiss) begin
            memReq_q  <= 1'b1;
            memWe_q   <= 1'b0;
            memAddr_q <= ALUResultM;
            state_q   <= RD;
          end else if (count_q != '0) begin
            memReq_q   <= 1'b1;
            memWe_q    <= 1'b1;
            memAddr_q  <= entryAddr_q[head_q];
            memWData_q <= entryData_q[head_q];
            state_q    <= WR;
          end
        end
        WR: begin
          if (MemAck) begin
            memReq_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RD: begin
          if (MemAck) begin
            readData_q <= MemRData;
            loaded_q   <= 1'b1;
            memReq_q   <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipelined core's memory stage and a slower data memory.
- Stores from the M stage are queued and drained over a req/ack memory bus. The core stalls only when the buffer is full or a load misses.
- Loads whose word address matches a queued store take the youngest matching data with zero latency.
- The core's hazard logic consumes the stall output.

Parameters:
- DEPTH, 4, number of store entries (power of two, ≥2).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset (0 = reset).
- MemWriteM  input  1  store request from M stage; held by core while StallMem=1.
- MemReadM  input  1  load request from M stage; held by core while StallMem=1.
- ALUResultM  input  AW  byte address; compared on [AW-1:2].
- WriteDataM  input  DW  store data.
- ReadDataM  output  DW  load data to W-stage pipe register.
- StallMem  output  1  freeze F/D/E/M stages this cycle.
- MemReq  output  1  memory request valid.
- MemWe  output  1  1 = write, 0 = read.
- MemAddr  output  AW  memory address.
- MemWData  output  DW  memory write data.
- MemAck  input  1  one-cycle completion pulse from memory.
- MemRData  input  DW  read data, valid with MemAck.
- Empty  output  1  no queued stores (for fences/halt).

Behaviour:
- Reset (reset=0, async):
  - count=0, head/tail pointers=0, FSM=IDLE.
  - MemReq=0, MemWe=0, MemAddr=0, MemWData=0.
  - ReadDataM=0, loaded flag=0, StallMem=0, Empty=1.
  - An in-flight memory transaction is abandoned. Any MemAck while in IDLE is ignored.
- FIFO: circular with head/tail pointers and a count of width log2(DEPTH)+1. Full = (count==DEPTH).
- Enqueue:
  - When MemWriteM=1 and not full: write {ALUResultM, WriteDataM} at tail on the clock edge. StallMem=0.
  - When full: StallMem=1 and no enqueue; the core retries the next cycle with held inputs.
  - Full is based on the registered count. A dequeue in the same cycle does not free a slot until the next cycle.
- Load forwarding (combinational):
  - Hit = any valid entry with addr[AW-1:2]==ALUResultM[AW-1:2]. The youngest matching entry wins.
  - On a hit, ReadDataM = entry data in the same cycle and StallMem=0.
  - The entry being drained counts as valid until its MemAck.
- Load miss:
  - StallMem=1 until the load completes.
  - Loads take priority over draining, but only when the FSM is IDLE. An outstanding store finishes first.
- FSM states:
  - IDLE:
    - If a load miss: MemReq=1, MemWe=0, MemAddr=ALUResultM; go to RD.
    - Else if count>0: MemReq=1, MemWe=1, addr/data from head; go to WR.
  - WR:
    - Hold MemReq, MemWe, MemAddr and MemWData stable.
    - On MemAck: head++, count--, MemReq=0; go to IDLE.
  - RD:
    - Hold the request.
    - On MemAck: latch MemRData into ReadDataM, set loaded=1, MemReq=0; go to IDLE.
- The request is registered, so MemReq rises the cycle after the FSM decision. Minimum occupancy is 2 cycles per transaction: request, then ack (ack may arrive the cycle MemReq is first high).
- Load completion:
  - The cycle after the RD ack: StallMem=0, ReadDataM holds the latched data, the core advances.
  - loaded clears on that edge.
  - Load latency = ack cycle + 1.
- Simultaneous enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Pointer wrap-around occurs modulo DEPTH.
- MemReadM and MemWriteM are never both 1. If they are, the store takes precedence and the load is stalled.
- Empty = (count==0) && FSM!=WR.

Test Plan:
1. Reset with MemReq=1 mid-WR:
   - Stimulus: assert reset=0.
   - Required: outputs go to reset values immediately; after release, a stray MemAck causes no pointer change.
2. Single store:
   - Stimulus: store 0x100 ← 0xDEADBEEF, memory acks 2 cycles after MemReq.
   - Required: no stall; MemReq/MemWe=1, MemAddr=0x100, MemWData=0xDEADBEEF held until ack; Empty returns to 1.
3. Fill to full:
   - Stimulus: 5 back-to-back stores, DEPTH=4, memory never acks.
   - Required: stores 1–4 accepted; 5th sees StallMem=1; after the first ack, the 5th is accepted the following cycle.
4. Forwarding:
   - Stimulus: stores 0x200←0x11, 0x204←0x22, 0x200←0x33, then load 0x202.
   - Required: ReadDataM=0x33 the same cycle, StallMem=0.
5. Load miss behind a pending store:
   - Stimulus: one queued store to 0x300 in WR, then load 0x400; memory returns 0xCAFE.
   - Required: store completes first, then RD to 0x400; StallMem drops the cycle after the RD ack with ReadDataM=0xCAFE.
6. Wrap-around:
   - Stimulus: 10 stores with interleaved acks.
   - Required: memory sees all 10 addr/data pairs in program order; count never exceeds 4.
